// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and forwarding controller for the 5-stage RV32 pipeline.
// Tracks destination-register info for EX/MEM/WB in a shadow pipeline. It
// produces registered EX operand forward selects, load-use stalls and
// taken-branch flushes.
// Optional feature: `define HAZARD_FWD_EN enables operand forwarding. When it
// is undefined, every RAW hazard against an EX or MEM producer is resolved by
// stalling, and the forward selects are tied to 00.

// Per-source-operand hazard detect: flags a match against the EX / MEM producer.
module ex_hazard_src #(
  parameter int REG_SEL = 5
) (
  input  logic               use_rs,
  input  logic [REG_SEL-1:0] rs,
  input  logic               ex_prod,
  input  logic [REG_SEL-1:0] ex_rd,
  input  logic               mem_prod,
  input  logic [REG_SEL-1:0] mem_rd,
  output logic               hit_ex,
  output logic               hit_mem
);
  // Producers are already qualified as valid & wr & rd!=0, so x0 never hits.
  assign hit_ex  = use_rs & ex_prod  & (rs == ex_rd);
  assign hit_mem = use_rs & mem_prod & (rs == mem_rd);
endmodule

module ex_hazard_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_SEL-1:0]   id_rs1,
  input  logic [REG_SEL-1:0]   id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_SEL-1:0]   id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 ex_branch_taken,
  output logic [1:0]           sel_forward1,
  output logic [1:0]           sel_forward2,
  output logic                 stall,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [CNT_WIDTH-1:0] stall_count
);
  localparam int STAGES  = 2;
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [REG_SEL-1:0] rd;
    logic               wr;
    logic               ld;
  } ex_info_t;

  typedef struct packed {
    logic [REG_SEL-1:0] rd;
    logic               wr;
  } mem_info_t;

  // vld_pipe[0]=EX, [1]=MEM, [2]=WB. WB only needs its valid bit: the regfile
  // is write-through, so a WB producer never has to be forwarded.
  logic [STAGES:0]                  vld_pipe;
  ex_info_t                         ex_q;
  mem_info_t                        mem_q;
  logic                             ex_prod, mem_prod;
  logic                             ex_load, raw_stall;
  logic [NUM_SRC-1:0]               src_use, hit_ex, hit_mem;
  logic [NUM_SRC-1:0][REG_SEL-1:0]  src_idx;

  assign src_use  = {id_use_rs2, id_use_rs1};
  assign src_idx  = {id_rs2, id_rs1};
  assign ex_prod  = vld_pipe[0] & ex_q.wr  & (ex_q.rd  != '0);
  assign mem_prod = vld_pipe[1] & mem_q.wr & (mem_q.rd != '0);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ex_hazard_src #(.REG_SEL(REG_SEL)) u_src (
      .use_rs   (src_use[i]),
      .rs       (src_idx[i]),
      .ex_prod  (ex_prod),
      .ex_rd    (ex_q.rd),
      .mem_prod (mem_prod),
      .mem_rd   (mem_q.rd),
      .hit_ex   (hit_ex[i]),
      .hit_mem  (hit_mem[i])
    );
  end

`ifdef HAZARD_FWD_EN
  logic [NUM_SRC-1:0][1:0] sel_d, sel_q;

  // Forward select for the instruction now in ID; youngest producer wins.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hit_ex[i])       sel_d[i] = 2'b01;
      else if (hit_mem[i]) sel_d[i] = 2'b10;
    end
  end

  // Register selects so they line up with the instruction once it sits in EX.
  always_ff @(posedge clk) begin
    if (rst)          sel_q <= '0;
    else if (ex_load) sel_q <= sel_d;
    else              sel_q <= '0;
  end

  assign sel_forward1 = sel_q[0];
  assign sel_forward2 = sel_q[1];
  // Only a load in EX cannot be forwarded in time.
  assign raw_stall    = ex_q.ld & (|hit_ex);
`else
  assign sel_forward1 = 2'b00;
  assign sel_forward2 = 2'b00;
  // No bypass paths: wait until every producer has reached WB.
  assign raw_stall    = (|hit_ex) | (|hit_mem);
`endif

  // A taken branch in EX overrides any stall; flushes need a live pipeline.
  assign stall       = id_valid & ~ex_branch_taken & raw_stall;
  assign flush_if_id = ex_branch_taken & (|vld_pipe);
  assign flush_id_ex = ex_branch_taken & (|vld_pipe);
  assign ex_load     = id_valid & ~stall & ~ex_branch_taken;

  // Shadow pipeline: ID info enters EX unless stalled or flushed (bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], ex_load};
      mem_q    <= '{rd: ex_q.rd, wr: ex_q.wr};
      if (ex_load) ex_q <= '{rd: id_rd, wr: id_reg_write, ld: id_mem_read};
      else         ex_q <= '0;
    end
  end

  // Stall performance counter; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)        stall_count <= '0;
    else if (stall) stall_count <= stall_count + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed test-plan scenarios plus a
// randomized run against an instruction-history reference model.
module tb_ex_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken;
  logic [1:0]  sel_forward1, sel_forward2;
  logic        stall, flush_if_id, flush_id_ex;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.NUM_REGS(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .sel_forward1(sel_forward1), .sel_forward2(sel_forward2),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_count(stall_count)
  );

  // Reference model: hist[d] is the instruction that entered EX d cycles ago
  // (1 = now in EX, 2 = MEM, 3 = WB); invalid entries are bubbles.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } ins_t;

  ins_t        hist [1:3];
  bit   [1:0]  m_sel1, m_sel2;
  bit   [31:0] m_cnt;

  function automatic bit m_dep(int d, bit u, bit [4:0] r);
    return u && hist[d].v && hist[d].wr && hist[d].rd != 0 && hist[d].rd == r;
  endfunction

  function automatic bit m_stall();
    bit d1, d2;
    d1 = m_dep(1, id_use_rs1, id_rs1) || m_dep(1, id_use_rs2, id_rs2);
    d2 = m_dep(2, id_use_rs1, id_rs1) || m_dep(2, id_use_rs2, id_rs2);
    if (!id_valid || ex_branch_taken) return 1'b0;
    if (FWD) return d1 && hist[1].ld;
    return d1 || d2;
  endfunction

  function automatic bit m_flush();
    return ex_branch_taken && (hist[1].v || hist[2].v || hist[3].v);
  endfunction

  function automatic bit [1:0] m_sel(bit u, bit [4:0] r);
    if (m_dep(1, u, r)) return 2'b01;
    if (m_dep(2, u, r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic m_clear();
    for (int d = 1; d <= 3; d++) hist[d] = '{1'b0, 5'd0, 1'b0, 1'b0};
    m_sel1 = 2'b00;
    m_sel2 = 2'b00;
    m_cnt  = 32'd0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic m_advance();
    bit s, iss;
    if (rst) begin
      m_clear();
    end else begin
      s   = m_stall();
      iss = id_valid && !s && !ex_branch_taken;
      if (FWD) begin
        m_sel1 = iss ? m_sel(id_use_rs1, id_rs1) : 2'b00;
        m_sel2 = iss ? m_sel(id_use_rs2, id_rs2) : 2'b00;
      end
      if (s) m_cnt = m_cnt + 32'd1;
      hist[3] = hist[2];
      hist[2] = hist[1];
      if (iss) hist[1] = '{1'b1, id_rd, id_reg_write, id_mem_read};
      else     hist[1] = '{1'b0, 5'd0, 1'b0, 1'b0};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit u1,
                        input bit [4:0] rs2, input bit u2,
                        input bit [4:0] rd, input bit wr, input bit ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_branch_taken = 1'b0; idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_id(1, 1, 1, 0, 0, 3, 1, 1);       // lw x3
    tick();
    set_id(1, 3, 1, 3, 1, 4, 1, 0);       // add x4,x3,x3 (load-use)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
    total++; if (sel_forward1 !== 2'b00) begin bad++; $display("FAIL reset_sel1 got=%0b want=00", sel_forward1); end
    total++; if (sel_forward2 !== 2'b00) begin bad++; $display("FAIL reset_sel2 got=%0b want=00", sel_forward2); end
    total++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b%0b want=00", flush_if_id, flush_id_ex); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
  endtask

  task automatic test_alu_raw();
    int ns;
    ns = FWD ? 0 : 2;
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);       // add x5,x1,x2
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_raw_first got=%0b want=0", stall); end
    tick();
    set_id(1, 5, 1, 7, 1, 6, 1, 0);       // sub x6,x5,x7
    for (int k = 0; k <= ns; k++) begin
      #4;
      total++; if (stall !== (k < ns)) begin bad++; $display("FAIL alu_raw_stall k=%0d got=%0b want=%0b", k, stall, k < ns); end
      tick();
    end
    idle();
    #4;
    total++; if (sel_forward1 !== (FWD ? 2'b01 : 2'b00)) begin bad++; $display("FAIL alu_raw_sel1 got=%0b want=%0b", sel_forward1, FWD ? 2'b01 : 2'b00); end
    total++; if (sel_forward2 !== 2'b00) begin bad++; $display("FAIL alu_raw_sel2 got=%0b want=00", sel_forward2); end
    total++; if (stall_count !== 32'(ns)) begin bad++; $display("FAIL alu_raw_count got=%0d want=%0d", stall_count, ns); end
  endtask

  task automatic test_dist2();
    int ns;
    ns = FWD ? 0 : 1;
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);       // add x5
    tick();
    idle();                               // nop
    tick();
    set_id(1, 5, 1, 5, 1, 8, 1, 0);       // or x8,x5,x5
    for (int k = 0; k <= ns; k++) begin
      #4;
      total++; if (stall !== (k < ns)) begin bad++; $display("FAIL dist2_stall k=%0d got=%0b want=%0b", k, stall, k < ns); end
      tick();
    end
    idle();
    #4;
    total++; if (sel_forward1 !== (FWD ? 2'b10 : 2'b00)) begin bad++; $display("FAIL dist2_sel1 got=%0b want=%0b", sel_forward1, FWD ? 2'b10 : 2'b00); end
    total++; if (sel_forward2 !== (FWD ? 2'b10 : 2'b00)) begin bad++; $display("FAIL dist2_sel2 got=%0b want=%0b", sel_forward2, FWD ? 2'b10 : 2'b00); end
  endtask

  task automatic test_load_use();
    int ns;
    ns = FWD ? 1 : 2;
    do_reset();
    set_id(1, 1, 1, 0, 0, 3, 1, 1);       // lw x3
    tick();
    set_id(1, 3, 1, 3, 1, 4, 1, 0);       // add x4,x3,x3
    for (int k = 0; k <= ns; k++) begin
      #4;
      total++; if (stall !== (k < ns)) begin bad++; $display("FAIL load_use_stall k=%0d got=%0b want=%0b", k, stall, k < ns); end
      total++; if (stall_count !== 32'(k)) begin bad++; $display("FAIL load_use_count k=%0d got=%0d want=%0d", k, stall_count, k); end
      tick();
    end
    idle();
    #4;
    total++; if (sel_forward1 !== (FWD ? 2'b10 : 2'b00)) begin bad++; $display("FAIL load_use_sel1 got=%0b want=%0b", sel_forward1, FWD ? 2'b10 : 2'b00); end
    total++; if (sel_forward2 !== (FWD ? 2'b10 : 2'b00)) begin bad++; $display("FAIL load_use_sel2 got=%0b want=%0b", sel_forward2, FWD ? 2'b10 : 2'b00); end
  endtask

  task automatic test_x0_unused();
    do_reset();
    set_id(1, 1, 1, 0, 0, 0, 1, 1);       // lw x0
    tick();
    set_id(1, 0, 1, 0, 1, 1, 1, 0);       // add x1,x0,x0
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b want=0", stall); end
    tick();
    idle();
    #4;
    total++; if (sel_forward1 !== 2'b00 || sel_forward2 !== 2'b00) begin bad++; $display("FAIL x0_sel got=%0b/%0b want=00/00", sel_forward1, sel_forward2); end
    do_reset();
    set_id(1, 1, 1, 0, 0, 2, 1, 1);       // lw x2
    tick();
    set_id(1, 2, 1, 2, 0, 9, 1, 0);       // addi x9,x2,1 (rs2 field = x2, unused)
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL addi_rs1_stall got=%0b want=1", stall); end
    do_reset();
    set_id(1, 1, 1, 0, 0, 2, 1, 1);       // lw x2
    tick();
    set_id(1, 1, 1, 2, 0, 9, 1, 0);       // only the unused rs2 field matches
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL unused_rs2_stall got=%0b want=0", stall); end
    tick();
    idle();
    #4;
    total++; if (sel_forward2 !== 2'b00) begin bad++; $display("FAIL unused_rs2_sel got=%0b want=00", sel_forward2); end
  endtask

  task automatic test_branch_vs_stall();
    do_reset();
    set_id(1, 1, 1, 0, 0, 3, 1, 1);       // lw x3
    tick();
    set_id(1, 3, 1, 3, 1, 4, 1, 0);       // add x4,x3,x3 while branch taken
    ex_branch_taken = 1'b1;
    #4;
    total++; if (flush_if_id !== 1'b1) begin bad++; $display("FAIL branch_flush_if_id got=%0b want=1", flush_if_id); end
    total++; if (flush_id_ex !== 1'b1) begin bad++; $display("FAIL branch_flush_id_ex got=%0b want=1", flush_id_ex); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL branch_stall got=%0b want=0", stall); end
    tick();
    ex_branch_taken = 1'b0;
    #4;
    // EX now holds a bubble: with forwarding no load-use remains.
    total++; if (stall !== !FWD) begin bad++; $display("FAIL branch_bubble_stall got=%0b want=%0b", stall, !FWD); end
    total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL branch_flush_clear got=%0b want=0", flush_if_id); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL branch_count got=%0d want=0", stall_count); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, FWD);     // add x5 (lw x5 when forwarding)
    tick();
    set_id(1, 5, 1, 7, 1, 6, 1, 0);       // sub x6,x5,x7
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL midrst_pre_stall got=%0b want=1", stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%0b want=0", stall); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", stall_count); end
  endtask

  task automatic test_random();
    bit e_stall, e_flush;
    do_reset();
    m_clear();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_use_rs1   = ($urandom_range(0, 3) != 0);
      id_use_rs2   = ($urandom_range(0, 3) != 0);
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = id_reg_write && ($urandom_range(0, 2) == 0);
      #4;
      e_stall = m_stall();
      e_flush = m_flush();
      total++; if (stall !== e_stall) begin bad++; $display("FAIL rnd_stall i=%0d got=%0b want=%0b", i, stall, e_stall); end
      total++; if (flush_if_id !== e_flush) begin bad++; $display("FAIL rnd_flush_if_id i=%0d got=%0b want=%0b", i, flush_if_id, e_flush); end
      total++; if (flush_id_ex !== e_flush) begin bad++; $display("FAIL rnd_flush_id_ex i=%0d got=%0b want=%0b", i, flush_id_ex, e_flush); end
      total++; if (sel_forward1 !== m_sel1) begin bad++; $display("FAIL rnd_sel1 i=%0d got=%0b want=%0b", i, sel_forward1, m_sel1); end
      total++; if (sel_forward2 !== m_sel2) begin bad++; $display("FAIL rnd_sel2 i=%0d got=%0b want=%0b", i, sel_forward2, m_sel2); end
      total++; if (stall_count !== m_cnt) begin bad++; $display("FAIL rnd_count i=%0d got=%0d want=%0d", i, stall_count, m_cnt); end
      m_advance();
      tick();
    end
    rst = 1'b0;
    ex_branch_taken = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    ex_branch_taken = 1'b0;
    idle();
    tick();
    test_reset();
    test_alu_raw();
    test_dist2();
    test_load_use();
    test_x0_unused();
    test_branch_vs_stall();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of destination-register info for the EX, MEM and WB stages.
- From it, generates registered forwarding selects for the EX stage operand muxes, load-use stalls, and branch flushes.
- Sits beside the ID/EX pipeline register; its selects drive sel_forward1/sel_forward2 of the EX stage.

Parameters:
- NUM_REGS, 32, architectural register count
- REG_SEL, $clog2(NUM_REGS), register index width
- CNT_WIDTH, 32, stall performance counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1  in  REG_SEL  decode source 1 index
- id_rs2  in  REG_SEL  decode source 2 index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_SEL  decode destination index
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- sel_forward1  out  2  EX operand 1 select: 00 regfile data1, 01 mem_forward1, 10 wb_forward1
- sel_forward2  out  2  EX operand 2 select, same encoding
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- flush_if_id  out  1  squash IF/ID this cycle
- flush_id_ex  out  1  squash ID/EX this cycle
- stall_count  out  CNT_WIDTH  cycles with stall=1 since reset

Behaviour:
- Reset (rst=1 at a clk edge):
  - All shadow stages invalid; sel_forward1/2=00; stall_count=0.
  - stall, flush_if_id and flush_id_ex are combinational and read 0 while the shadow stages are invalid.
  - Reset mid-stall ends the stall on the following cycle.
- Shadow stages:
  - ex {valid, rd, wr, ld}, mem {valid, rd, wr}, wb {valid, rd, wr}.
  - Each clk: wb<=mem; mem<=ex.
  - ex<=decode info when id_valid & !stall & !ex_branch_taken; otherwise ex<=bubble (valid=0).
- Producer qualification: a stage counts as a producer only if valid & wr & rd!=0. x0 is never forwarded or stalled on.
- Load-use stall (combinational):
  - stall=1 when id_valid & ex is a producer with ld=1 & ((id_use_rs1 & id_rs1==ex.rd) | (id_use_rs2 & id_rs2==ex.rd)).
  - Exactly 1 cycle per load-use pair. The next cycle the load is in MEM, and no stall recurs.
- Forward selects:
  - Computed in ID and registered, so they are valid in the same cycle the instruction occupies EX.
  - For operand n (n = 1, 2):
    - if use_rsn & ex is a producer & rsn==ex.rd -> 01 (producer will be in MEM);
    - else if use_rsn & mem is a producer & rsn==mem.rd -> 10 (producer will be in WB);
    - else 00.
  - Youngest producer wins.
  - A producer in WB while the consumer is in ID needs no forward: the regfile is write-through.
  - On a stall or flush cycle the registered selects load 00.
- Branch:
  - ex_branch_taken=1 -> flush_if_id=1 and flush_id_ex=1 in the same cycle.
  - Branch has priority over stall: stall is forced 0 when ex_branch_taken=1.
  - stall_count does not increment in that cycle.
- stall_count:
  - Increments by 1 on every cycle with stall=1.
  - Wraps from all-ones to 0.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: behaviour as above.
- Undefined: no forwarding.
  - sel_forward1/2 are constant 00.
  - stall=1 whenever id_valid and a used source matches an ex or mem producer (loads or not).
  - RAW distance 1 -> 2 stall cycles; distance 2 -> 1 stall cycle.
  - Branch priority and stall_count rules are unchanged.

Test Plan:
- ALU RAW, distance 1: add x5 then sub x6,x5,x7 back-to-back (HAZARD_FWD_EN) -> no stall; sel_forward1=01 while sub is in EX.
- Distance 2: add x5; nop; or x8,x5,x5 -> sel_forward1=10 and sel_forward2=10 in EX; no stall.
- Load-use: lw x3 then add x4,x3,x3 -> stall=1 for exactly 1 cycle; stall_count 0->1; then add in EX with sel_forward1=sel_forward2=10.
- x0 and unused sources: lw x0 then add x1,x0,x0; and addi x9,x2,1 after lw x2 with id_use_rs2=0 but id_rs2=x2 -> x0 case: stall=0 and selects 00; addi case: stall=1, since rs1 matches.
- Branch vs stall: ex_branch_taken=1 in the same cycle a load-use is detected -> flush_if_id=flush_id_ex=1, stall=0, stall_count unchanged; next cycle the ex stage is a bubble.
- Without HAZARD_FWD_EN: add x5 then sub x6,x5,x7 -> stall=1 for 2 cycles, sel_forward=00; rst asserted during the 1st stall cycle -> stall=0 the cycle after and stall_count=0.
